// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the single-ported
// data memory. Port 0 is the CPU load/store path, port 1 the DMA/debug
// loader. One access is in flight at a time, and a bus timeout releases
// a requester if the memory never drops busywait.
`timescale 1ns/1ps

module data_mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_read,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_address,
    input  logic [DATA_W-1:0] req0_writedata,
    output logic [DATA_W-1:0] req0_readdata,
    output logic              req0_busywait,
    input  logic              req1_read,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_address,
    input  logic [DATA_W-1:0] req1_writedata,
    output logic [DATA_W-1:0] req1_readdata,
    output logic              req1_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    // Last WAIT count value before the access is abandoned.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              lastGrant_q, lastGrant_d;
    logic              memRead_q, memRead_d;
    logic              memWrite_q, memWrite_d;
    logic [ADDR_W-1:0] memAddress_q, memAddress_d;
    logic [DATA_W-1:0] memWriteData_q, memWriteData_d;
    logic [DATA_W-1:0] readData0_q, readData0_d;
    logic [DATA_W-1:0] readData1_q, readData1_d;
    logic              timeoutErr_q, timeoutErr_d;
    logic [7:0]        timeoutCnt_q, timeoutCnt_d;

    logic valid0;
    logic valid1;
    logic pick0;
    logic pick1;

    // A request is only meaningful when exactly one of read/write is high.
    assign valid0 = req0_read ^ req0_write;
    assign valid1 = req1_read ^ req1_write;

    // Round-robin choice: on a tie the port that was not served last wins.
    assign pick0 = valid0 && (!valid1 || lastGrant_q);
    assign pick1 = valid1 && !pick0;

    // A requester stalls for as long as it asks, except in its own DONE cycle.
    assign req0_busywait = !reset && valid0 && !(state_q == DONE && grant_q == 1'b0);
    assign req1_busywait = !reset && valid1 && !(state_q == DONE && grant_q == 1'b1);

    assign mem_read      = memRead_q;
    assign mem_write     = memWrite_q;
    assign mem_address   = memAddress_q;
    assign mem_writedata = memWriteData_q;
    assign req0_readdata = readData0_q;
    assign req1_readdata = readData1_q;
    assign timeout_err   = timeoutErr_q;

    // Next-state logic: grant in IDLE, give memory a cycle to react in
    // ISSUE, wait for completion or timeout in WAIT, release in DONE.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        lastGrant_d    = lastGrant_q;
        memRead_d      = memRead_q;
        memWrite_d     = memWrite_q;
        memAddress_d   = memAddress_q;
        memWriteData_d = memWriteData_q;
        readData0_d    = readData0_q;
        readData1_d    = readData1_q;
        timeoutErr_d   = timeoutErr_q;
        timeoutCnt_d   = timeoutCnt_q;

        case (state_q)
            IDLE: begin
                if (pick0) begin
                    grant_d        = 1'b0;
                    memRead_d      = req0_read;
                    memWrite_d     = req0_write;
                    memAddress_d   = req0_address;
                    memWriteData_d = req0_writedata;
                    state_d        = ISSUE;
                end else if (pick1) begin
                    grant_d        = 1'b1;
                    memRead_d      = req1_read;
                    memWrite_d     = req1_write;
                    memAddress_d   = req1_address;
                    memWriteData_d = req1_writedata;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                timeoutCnt_d = 8'd0;
                state_d      = WAIT;
            end
            WAIT: begin
                if (!mem_busywait) begin
                    if (memRead_q) begin
                        if (grant_q) begin
                            readData1_d = mem_readdata;
                        end else begin
                            readData0_d = mem_readdata;
                        end
                    end
                    memRead_d  = 1'b0;
                    memWrite_d = 1'b0;
                    state_d    = DONE;
                end else if (timeoutCnt_q == TIMEOUT_LAST) begin
                    memRead_d    = 1'b0;
                    memWrite_d   = 1'b0;
                    timeoutErr_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    timeoutCnt_d = timeoutCnt_q + 8'd1;
                end
            end
            DONE: begin
                lastGrant_d = grant_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any in-flight access immediately.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            grant_q        <= 1'b0;
            lastGrant_q    <= 1'b1;
            memRead_q      <= 1'b0;
            memWrite_q     <= 1'b0;
            memAddress_q   <= '0;
            memWriteData_q <= '0;
            readData0_q    <= '0;
            readData1_q    <= '0;
            timeoutErr_q   <= 1'b0;
            timeoutCnt_q   <= 8'd0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            lastGrant_q    <= lastGrant_d;
            memRead_q      <= memRead_d;
            memWrite_q     <= memWrite_d;
            memAddress_q   <= memAddress_d;
            memWriteData_q <= memWriteData_d;
            readData0_q    <= readData0_d;
            readData1_q    <= readData1_d;
            timeoutErr_q   <= timeoutErr_d;
            timeoutCnt_q   <= timeoutCnt_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a behavioural memory, a transaction-level
// reference model checked every cycle, and directed scenarios with
// hand-computed results.
`timescale 1ns/1ps

module tb_data_mem_arbiter;

    localparam int TIMEOUT   = 64;
    localparam int STUCK_AGE = TIMEOUT + 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       req0_read, req0_write, req0_busywait;
    logic [7:0] req0_address, req0_writedata, req0_readdata;
    logic       req1_read, req1_write, req1_busywait;
    logic [7:0] req1_address, req1_writedata, req1_readdata;
    logic       mem_read, mem_write, mem_busywait, timeout_err;
    logic [7:0] mem_address, mem_writedata;
    logic [7:0] mem_readdata = 8'h00;

    int checks = 0;
    int errors = 0;

    data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .req0_read(req0_read), .req0_write(req0_write), .req0_address(req0_address),
        .req0_writedata(req0_writedata), .req0_readdata(req0_readdata), .req0_busywait(req0_busywait),
        .req1_read(req1_read), .req1_write(req1_write), .req1_address(req1_address),
        .req1_writedata(req1_writedata), .req1_readdata(req1_readdata), .req1_busywait(req1_busywait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural memory: accepts a strobe, stays busy for memLat edges,
    // then completes; waits for the strobes to drop before accepting again.
    logic [7:0] memArray [256];
    logic       memInit   = 1'b0;
    logic       memBusy   = 1'b0;
    logic       memServed = 1'b0;
    logic       stuck     = 1'b0;
    int         memCnt    = 0;
    int         memLat    = 1;

    assign mem_busywait = stuck | memBusy;

    always @(posedge clock) begin
        if (!memInit) begin
            for (int i = 0; i < 256; i++) memArray[i] <= 8'(i) ^ 8'h5A;
            memInit <= 1'b1;
        end else if (memBusy) begin
            if (memCnt <= 1) begin
                if (mem_write) memArray[mem_address] <= mem_writedata;
                else mem_readdata <= memArray[mem_address];
                memBusy   <= 1'b0;
                memServed <= 1'b1;
            end else begin
                memCnt <= memCnt - 1;
            end
        end else if (!stuck && (mem_read || mem_write) && !memServed) begin
            memBusy <= 1'b1;
            memCnt  <= memLat;
        end else if (!(mem_read || mem_write)) begin
            memServed <= 1'b0;
        end
    end

    // Reference model: a transaction at a time, owner chosen round-robin.
    logic [7:0] refMem [256];
    logic [7:0] expRd0, expRd1, ownAddr, ownData;
    logic       expErr, ownWrite, ownStuck, resetLast;
    logic       v0, v1, busyOwn, busyOther, vOther;
    int         owner, lastGrantM, age;
    int         grantLog[$];

    initial begin
        for (int i = 0; i < 256; i++) refMem[i] = 8'(i) ^ 8'h5A;
        owner = -1; lastGrantM = 1; expRd0 = 0; expRd1 = 0; expErr = 0; resetLast = 0; age = 0;
        ownWrite = 0; ownAddr = 0; ownData = 0; ownStuck = 0;
        forever begin
            @(negedge clock);
            v0 = req0_read ^ req0_write;
            v1 = req1_read ^ req1_write;
            if (reset) begin
                checkOutput("busy0 in reset", {31'd0, req0_busywait}, 0);
                checkOutput("busy1 in reset", {31'd0, req1_busywait}, 0);
                owner = -1; lastGrantM = 1; expRd0 = 0; expRd1 = 0; expErr = 0;
                resetLast = 1;
                continue;
            end
            if (resetLast) begin
                checkOutput("post-reset strobes", {30'd0, mem_read, mem_write}, 0);
                checkOutput("post-reset address", {24'd0, mem_address}, 0);
                checkOutput("post-reset wdata", {24'd0, mem_writedata}, 0);
                resetLast = 0;
            end
            checkOutput("strobe exclusive", {31'd0, mem_read & mem_write}, 0);
            if (owner < 0) begin
                checkOutput("idle strobes", {30'd0, mem_read, mem_write}, 0);
                checkOutput("idle busy0", {31'd0, req0_busywait}, {31'd0, v0});
                checkOutput("idle busy1", {31'd0, req1_busywait}, {31'd0, v1});
                if (v0 || v1) begin
                    owner    = (v0 && (!v1 || lastGrantM == 1)) ? 0 : 1;
                    ownWrite = (owner == 0) ? req0_write : req1_write;
                    ownAddr  = (owner == 0) ? req0_address : req1_address;
                    ownData  = (owner == 0) ? req0_writedata : req1_writedata;
                    ownStuck = stuck;
                    age      = 0;
                end
            end else begin
                age++;
                busyOwn   = (owner == 0) ? req0_busywait : req1_busywait;
                busyOther = (owner == 0) ? req1_busywait : req0_busywait;
                vOther    = (owner == 0) ? v1 : v0;
                checkOutput("other port stalls", {31'd0, busyOther}, {31'd0, vOther});
                if (!busyOwn) begin
                    checkOutput("done strobes", {30'd0, mem_read, mem_write}, 0);
                    if (ownStuck) begin
                        checkOutput("timeout age", age, STUCK_AGE);
                        expErr = 1;
                    end else begin
                        checkOutput("access latency", {31'd0, age >= 3 && age <= 20}, 1);
                        if (ownWrite) refMem[ownAddr] = ownData;
                        else if (owner == 0) expRd0 = refMem[ownAddr];
                        else expRd1 = refMem[ownAddr];
                    end
                    grantLog.push_back(owner);
                    lastGrantM = owner;
                    owner = -1;
                end else begin
                    checkOutput("active strobes", {30'd0, mem_read, mem_write}, {30'd0, !ownWrite, ownWrite});
                    checkOutput("active address", {24'd0, mem_address}, {24'd0, ownAddr});
                    if (ownWrite) checkOutput("active wdata", {24'd0, mem_writedata}, {24'd0, ownData});
                    if (age > STUCK_AGE + 10) begin
                        checkOutput("access watchdog", age, STUCK_AGE);
                        owner = -1;
                    end
                end
            end
            checkOutput("readdata0", {24'd0, req0_readdata}, {24'd0, expRd0});
            checkOutput("readdata1", {24'd0, req1_readdata}, {24'd0, expRd1});
            checkOutput("timeout_err", {31'd0, timeout_err}, {31'd0, expErr});
        end
    end

    // Raise a request on one port, hold it until served, then drop it.
    task automatic applyStimulus(input int port, input logic rd, input logic wr,
                                 input logic [7:0] addr, input logic [7:0] data, output int cycles);
        logic busy;
        @(posedge clock); #1;
        if (port == 0) begin
            req0_read = rd; req0_write = wr; req0_address = addr; req0_writedata = data;
        end else begin
            req1_read = rd; req1_write = wr; req1_address = addr; req1_writedata = data;
        end
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
            busy = (port == 0) ? req0_busywait : req1_busywait;
        end while (busy && cycles < 200);
        if (busy) checkOutput("request wait bound", cycles, 0);
        @(posedge clock); #1;
        if (port == 0) begin
            req0_read = 0; req0_write = 0;
        end else begin
            req1_read = 0; req1_write = 0;
        end
    endtask

    task automatic pulseReset();
        @(posedge clock); #1 reset = 1;
        @(posedge clock); #1 reset = 0;
    endtask

    int c0, c1;

    initial begin
        reset = 1;
        req0_read = 0; req0_write = 0; req0_address = 0; req0_writedata = 0;
        req1_read = 0; req1_write = 0; req1_address = 0; req1_writedata = 0;
        repeat (3) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        checkOutput("reset readdata0", {24'd0, req0_readdata}, 0);
        checkOutput("reset timeout_err", {31'd0, timeout_err}, 0);

        $display("[TB] port 0 write then read");
        applyStimulus(0, 0, 1, 8'h10, 8'hA5, c0);
        applyStimulus(0, 1, 0, 8'h10, 8'h00, c0);
        checkOutput("port0 read 0x10", {24'd0, req0_readdata}, 32'hA5);
        checkOutput("read latency", c0, 5);

        $display("[TB] simultaneous reads alternate");
        pulseReset();
        grantLog.delete();
        fork
            applyStimulus(0, 1, 0, 8'h01, 8'h00, c0);
            applyStimulus(1, 1, 0, 8'h02, 8'h00, c1);
        join
        checkOutput("tie read port0", {24'd0, req0_readdata}, 32'h5B);
        checkOutput("tie read port1", {24'd0, req1_readdata}, 32'h58);
        fork
            applyStimulus(0, 1, 0, 8'h01, 8'h00, c0);
            applyStimulus(1, 1, 0, 8'h02, 8'h00, c1);
        join
        checkOutput("grant count", grantLog.size(), 4);
        for (int i = 0; i < 4 && i < grantLog.size(); i++)
            checkOutput("grant order", grantLog[i], i % 2);

        $display("[TB] write held during other port read");
        fork
            applyStimulus(0, 1, 0, 8'h20, 8'h00, c0);
            applyStimulus(1, 0, 1, 8'h20, 8'h3C, c1);
        join
        checkOutput("old value read", {24'd0, req0_readdata}, 32'h7A);
        applyStimulus(0, 1, 0, 8'h20, 8'h00, c0);
        checkOutput("new value read", {24'd0, req0_readdata}, 32'h3C);

        $display("[TB] illegal request on port 0");
        @(posedge clock); #1;
        req0_read = 1; req0_write = 1; req0_address = 8'h07;
        @(negedge clock);
        checkOutput("illegal busy0", {31'd0, req0_busywait}, 0);
        applyStimulus(1, 1, 0, 8'h05, 8'h00, c1);
        checkOutput("port1 read 0x05", {24'd0, req1_readdata}, 32'h5F);
        checkOutput("port0 untouched", {24'd0, req0_readdata}, 32'h3C);
        req0_read = 0; req0_write = 0;

        $display("[TB] stuck memory timeout");
        stuck = 1;
        applyStimulus(0, 1, 0, 8'h30, 8'h00, c0);
        stuck = 0;
        checkOutput("timeout latency", c0, TIMEOUT + 3);
        checkOutput("timeout flag", {31'd0, timeout_err}, 1);
        checkOutput("timeout readdata", {24'd0, req0_readdata}, 32'h3C);

        $display("[TB] reset during WAIT");
        @(posedge clock); #1;
        stuck = 1; req0_read = 1; req0_address = 8'h40;
        repeat (8) @(posedge clock);
        #1;
        req1_read = 1; req1_address = 8'h41;
        reset = 1; req0_read = 0;
        @(posedge clock); #1;
        reset = 0; stuck = 0;
        @(negedge clock);
        checkOutput("reset strobes", {30'd0, mem_read, mem_write}, 0);
        checkOutput("reset busy0", {31'd0, req0_busywait}, 0);
        checkOutput("reset clears err", {31'd0, timeout_err}, 0);
        checkOutput("reset readdata0 again", {24'd0, req0_readdata}, 0);
        c1 = 0;
        while (req1_busywait && c1 < 200) begin
            @(negedge clock);
            c1++;
        end
        checkOutput("pending port1 served", {31'd0, req1_busywait}, 0);
        checkOutput("port1 read 0x41", {24'd0, req1_readdata}, 32'h1B);
        @(posedge clock); #1 req1_read = 0;

        repeat (4) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL global time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-ported 256x8 data memory.
- Port 0 is the CPU load/store path and port 1 is the DMA/debug loader path. Both use the memory's level read/write + busywait handshake unchanged.
- The block grants one requester at a time with round-robin priority and drives the memory strobes.
- It runs a bus timeout so a stuck memory cannot hang the CPU.

Parameters:
- ADDR_W, 8, address width of requesters and memory.
- DATA_W, 8, data width.
- TIMEOUT, 64, maximum cycles spent in WAIT before the access is aborted (1..255).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- req0_read  input  1  port 0 read request (level).
- req0_write  input  1  port 0 write request (level).
- req0_address  input  ADDR_W  port 0 address.
- req0_writedata  input  DATA_W  port 0 write data.
- req0_readdata  output  DATA_W  port 0 read data, registered.
- req0_busywait  output  1  port 0 stall.
- req1_read, req1_write, req1_address, req1_writedata, req1_readdata, req1_busywait: same as port 0, for port 1.
- mem_read  output  1  memory read strobe, registered.
- mem_write  output  1  memory write strobe, registered.
- mem_address  output  ADDR_W  registered.
- mem_writedata  output  DATA_W  registered.
- mem_readdata  input  DATA_W  memory read data.
- mem_busywait  input  1  memory busy.
- timeout_err  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (synchronous, active-high; clock clock)
  - State IDLE; mem_read/mem_write 0; mem_address/mem_writedata 0.
  - req0_readdata/req1_readdata 0; timeout_err 0; last_grant=1, so port 0 wins the first tie; timeout counter 0.
  - While reset is high both reqN_busywait are 0.
  - Reset mid-access returns to IDLE immediately. The in-flight access is abandoned and its readdata is not updated.
- Valid request
  - reqN_valid = reqN_read XOR reqN_write.
  - Read and write both high is illegal and treated as no request: busywait 0, never granted.
- reqN_busywait (combinational)
  - Equals reqN_valid AND NOT (state==DONE AND grant==N).
  - So a requester stalls from the same cycle it raises a request, including while waiting for the other port.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE
  - No valid request: stay.
  - One valid request: grant it.
  - Both valid: grant the port != last_grant.
  - On grant, at the edge: latch address, writedata and read/write onto mem_* (registered), set grant, go to ISSUE.
  - Requester inputs are captured only here; changes during the access are ignored.
- ISSUE
  - Hold strobes for one cycle so the memory sees the request and raises busywait.
  - Unconditionally go to WAIT; clear timeout counter.
- WAIT
  - Hold strobes.
  - mem_busywait sampled 0 at an edge: if read, load mem_readdata into reqG_readdata; drop mem_read/mem_write; go to DONE.
  - Else increment counter. When counter reaches TIMEOUT-1: drop strobes, set timeout_err, leave readdata unchanged, go to DONE (access aborted but released).
- DONE
  - Granted port's busywait is low for exactly this cycle; set last_grant=grant; go to IDLE.
  - A requester still asserting a valid request in IDLE starts a new access. Back-to-back accesses from one port are legal, but round-robin alternates whenever both are valid.
- Latency
  - Request seen at IDLE edge E0; strobes high from E0 to the WAIT exit edge.
  - With memory completing in one cycle, busywait falls in the cycle after edge E2. Minimum occupancy is 4 cycles per access (IDLE, ISSUE, WAIT, DONE).
- Only one memory access is in flight at a time; mem_read and mem_write are never high together.
- readdata of the non-granted port never changes.

Test Plan:
- Port 0 write addr 0x10 data 0xA5, then port 0 read 0x10 -> mem_write high with addr 0x10 and data 0xA5; req0_readdata=0xA5; req0_busywait low for exactly one cycle per access.
- Ports 0 and 1 both read at the same edge after reset (0x01, 0x02) -> port 0 served first, port 1 next.
  - Repeated simultaneous requests alternate 0,1,0,1.
  - req1_busywait stays high throughout port 0's access.
- Port 1 holds a write to 0x20=0x3C during a port 0 read of 0x20 (port 0 granted first) -> port 0 gets the old value; a later read returns 0x3C.
- Memory model holds mem_busywait high forever, port 0 read -> after TIMEOUT(64) WAIT cycles: strobes drop, timeout_err=1, req0_busywait pulses low once, req0_readdata unchanged.
- Reset asserted in WAIT -> next edge: IDLE, strobes 0, busywaits 0, timeout_err 0. After reset, a pending port 1 request is granted cleanly.
- req0_read and req0_write both high -> no memory access, req0_busywait=0; a port 1 request is still served normally.
